// File: rtl/sva_req_ack_window_checker_if.sv
// ============================================================================
// sva_req_ack_window_checker_if : req/ack monitor stimulus and result bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sva_req_ack_window_checker_if #(
  parameter int NCH = 4
) ();
  logic           en;
  logic [NCH-1:0] req;
  logic [NCH-1:0] ack;
  logic           eot;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] pass_pulse;
  logic [NCH-1:0] fail_pulse;
  logic [15:0]    pass_count;
  logic [15:0]    fail_count;
  logic           first_fail_valid;
  logic [4:0]     first_fail_ch;

  modport master (
    output en, req, ack, eot,
    input  pending, pass_pulse, fail_pulse, pass_count, fail_count,
           first_fail_valid, first_fail_ch
  );

  modport slave (
    input  en, req, ack, eot,
    output pending, pass_pulse, fail_pulse, pass_count, fail_count,
           first_fail_valid, first_fail_ch
  );
endinterface

`default_nettype wire

// File: rtl/sva_req_ack_window_checker.sv
// ============================================================================
// sva_req_ack_window_checker : per-channel trig |-> ##[MIN_DLY:MAX_DLY] ack monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module sva_req_ack_window_checker #(
  parameter int NCH       = 4,
  parameter int MIN_DLY   = 1,
  parameter int MAX_DLY   = 0,
  parameter int CNTW      = 8,
  parameter int TRIG_MODE = 0,
  parameter int STRONG    = 0
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  sva_req_ack_window_checker_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] CNT_SAT = '1;
  localparam logic [CNTW-1:0] MIN_C   = CNTW'(MIN_DLY);
  localparam logic [CNTW-1:0] MAX_C   = CNTW'(MAX_DLY);

  state_t          state_q [NCH];
  state_t          state_d [NCH];
  logic [CNTW-1:0] cnt_q   [NCH];
  logic [CNTW-1:0] cnt_d   [NCH];

  logic [NCH-1:0]  req_hist_q;
  logic [NCH-1:0]  trig;
  logic [NCH-1:0]  pass_d, fail_d;
  logic [NCH-1:0]  pending_d;
  logic [NCH-1:0]  pass_pulse_q, fail_pulse_q, pending_q;
  logic [15:0]     pass_count_d, pass_count_q;
  logic [15:0]     fail_count_d, fail_count_q;
  logic            first_fail_valid_d, first_fail_valid_q;
  logic [4:0]      first_fail_ch_d, first_fail_ch_q;
  logic [5:0]      pass_num, fail_num;
  logic [16:0]     pass_sum, fail_sum;

  always_comb begin
    trig      = '0;
    pass_d    = '0;
    fail_d    = '0;
    pending_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      trig[i]    = (TRIG_MODE != 0) ? (bus.req[i] & ~bus.ack[i])
                                    : (bus.req[i] & ~req_hist_q[i]);
      if (!bus.en) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else if (state_q[i] == IDLE) begin
        if (trig[i]) begin
          if (MIN_DLY == 0 && bus.ack[i]) begin
            pass_d[i] = 1'b1;
          end else begin
            state_d[i] = WAIT;
            cnt_d[i]   = CNTW'(1);
          end
        end
      end else if (bus.eot) begin
        // End of test overrides any same-cycle resolution of the obligation
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        fail_d[i]  = (STRONG != 0);
      end else if (bus.ack[i] && cnt_q[i] >= MIN_C) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        pass_d[i]  = 1'b1;
      end else if (MAX_DLY != 0 && cnt_q[i] == MAX_C) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
        fail_d[i]  = 1'b1;
      end else if (cnt_q[i] != CNT_SAT) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end
      pending_d[i] = (state_d[i] == WAIT);
    end
  end

  always_comb begin
    pass_num = '0;
    fail_num = '0;
    for (int i = 0; i < NCH; i++) begin
      pass_num = pass_num + 6'(pass_d[i]);
      fail_num = fail_num + 6'(fail_d[i]);
    end
    pass_sum     = {1'b0, pass_count_q} + 17'(pass_num);
    fail_sum     = {1'b0, fail_count_q} + 17'(fail_num);
    pass_count_d = pass_sum[16] ? 16'hFFFF : pass_sum[15:0];
    fail_count_d = fail_sum[16] ? 16'hFFFF : fail_sum[15:0];

    first_fail_valid_d = first_fail_valid_q;
    first_fail_ch_d    = first_fail_ch_q;
    if (!first_fail_valid_q && (|fail_d)) begin
      first_fail_valid_d = 1'b1;
      // Descending scan leaves the lowest failing index latched
      for (int i = NCH - 1; i >= 0; i--) begin
        if (fail_d[i]) first_fail_ch_d = 5'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      req_hist_q         <= '0;
      pending_q          <= '0;
      pass_pulse_q       <= '0;
      fail_pulse_q       <= '0;
      pass_count_q       <= '0;
      fail_count_q       <= '0;
      first_fail_valid_q <= 1'b0;
      first_fail_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      req_hist_q         <= bus.req;
      pending_q          <= pending_d;
      pass_pulse_q       <= pass_d;
      fail_pulse_q       <= fail_d;
      pass_count_q       <= pass_count_d;
      fail_count_q       <= fail_count_d;
      first_fail_valid_q <= first_fail_valid_d;
      first_fail_ch_q    <= first_fail_ch_d;
    end
  end

  assign bus.pending          = pending_q;
  assign bus.pass_pulse       = pass_pulse_q;
  assign bus.fail_pulse       = fail_pulse_q;
  assign bus.pass_count       = pass_count_q;
  assign bus.fail_count       = fail_count_q;
  assign bus.first_fail_valid = first_fail_valid_q;
  assign bus.first_fail_ch    = first_fail_ch_q;

endmodule

`default_nettype wire
